// File: rtl/shot_sequencer.sv
// shot_sequencer: DSP-side shot control. Issues one shot_trig per shot, waits for the
// core's shot_done, inserts an optional idle gap, and reports shotcnt/lastshotdone.
module shot_sequencer #(
   parameter int unsigned NSHOTWIDTH = 32,
   parameter int unsigned GAPWIDTH   = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stb_start,
   input  logic                  stb_abort,
   input  logic [NSHOTWIDTH-1:0] nshot,
   input  logic [GAPWIDTH-1:0]   shotgap,
   input  logic                  resetacc,
   input  logic                  shot_done,
   output logic                  shot_trig,
   output logic                  acc_clear,
   output logic [NSHOTWIDTH-1:0] shotcnt,
   output logic                  lastshotdone,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StTrig, StWaitDone, StGap} state_e;

   state_e                state;
   logic [NSHOTWIDTH-1:0] nshot_q;
   logic [GAPWIDTH-1:0]   gap_q;
   logic [GAPWIDTH-1:0]   gapcnt;
   logic [NSHOTWIDTH-1:0] cnt_inc;

   // Count cannot overflow: a run ends as soon as it reaches the latched nshot.
   assign cnt_inc = shotcnt + NSHOTWIDTH'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         nshot_q      <= '0;
         gap_q        <= '0;
         gapcnt       <= '0;
         shotcnt      <= '0;
         lastshotdone <= 1'b0;
         shot_trig    <= 1'b0;
         acc_clear    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         shot_trig <= 1'b0;
         acc_clear <= 1'b0;
         if (stb_abort) begin
            // Abort wins over everything; the count is left for readback.
            state <= StIdle;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (stb_start) begin
                     shotcnt <= '0;
                     if (nshot != '0) begin
                        nshot_q      <= nshot;
                        gap_q        <= shotgap;
                        lastshotdone <= 1'b0;
                        state        <= StTrig;
                        shot_trig    <= 1'b1;
                        acc_clear    <= resetacc;
                        busy         <= 1'b1;
                     end else begin
                        lastshotdone <= 1'b1;
                     end
                  end
               end
               StTrig: begin
                  state <= StWaitDone;
               end
               StWaitDone: begin
                  if (shot_done) begin
                     shotcnt <= cnt_inc;
                     if (cnt_inc == nshot_q) begin
                        lastshotdone <= 1'b1;
                        state        <= StIdle;
                        busy         <= 1'b0;
                     end else if (gap_q == '0) begin
                        state     <= StTrig;
                        shot_trig <= 1'b1;
                     end else begin
                        gapcnt <= gap_q;
                        state  <= StGap;
                     end
                  end
               end
               StGap: begin
                  gapcnt <= gapcnt - GAPWIDTH'(1);
                  if (gapcnt == GAPWIDTH'(1)) begin
                     state     <= StTrig;
                     shot_trig <= 1'b1;
                  end
               end
               default: begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: randomized bench for shot_sequencer against an event-timing model
// (expected trigger cycle, count and flags derived from shot_done arrival times).
module tb_shot_sequencer;

   localparam int NW = 32;
   localparam int GW = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic          stb_start;
   logic          stb_abort;
   logic [NW-1:0] nshot;
   logic [GW-1:0] shotgap;
   logic          resetacc;
   logic          shot_done;
   logic          shot_trig;
   logic          acc_clear;
   logic [NW-1:0] shotcnt;
   logic          lastshotdone;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Expected outputs for the cycle about to be observed
   int m_cnt  = 0;
   bit m_last = 1'b0;
   bit m_busy = 1'b0;

   shot_sequencer #(.NSHOTWIDTH(NW), .GAPWIDTH(GW)) dut (
      .clk          (clk),
      .reset        (reset),
      .stb_start    (stb_start),
      .stb_abort    (stb_abort),
      .nshot        (nshot),
      .shotgap      (shotgap),
      .resetacc     (resetacc),
      .shot_done    (shot_done),
      .shot_trig    (shot_trig),
      .acc_clear    (acc_clear),
      .shotcnt      (shotcnt),
      .lastshotdone (lastshotdone),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Inputs are driven at negedge; outputs observed at negedge belong to cycle cyc.
   task automatic run_shots(input int n, input int g, input bit racc, input int lat_fix,
                            input int abort_at, input bit noise);
      int next_trig;
      int done_cyc;
      int dones;
      int idle;
      int budget;
      bit clr;
      @(negedge clk);
      stb_start = 1'b1;
      stb_abort = 1'b0;
      shot_done = 1'b0;
      nshot     = NW'(n);
      shotgap   = GW'(g);
      resetacc  = racc;
      m_cnt     = 0;
      if (n == 0) begin
         m_last    = 1'b1;
         m_busy    = 1'b0;
         next_trig = -1;
      end else begin
         m_last    = 1'b0;
         m_busy    = 1'b1;
         next_trig = cyc + 1;
      end
      clr      = racc;
      done_cyc = -1;
      dones    = 0;
      idle     = 0;
      budget   = 0;
      while (idle < 4) begin
         @(negedge clk);
         stb_start = 1'b0;
         stb_abort = 1'b0;
         shot_done = 1'b0;
         n_checks++;
         if (shot_trig !== (cyc == next_trig)) begin
            n_fail++;
            $display("FAIL shot_trig cyc=%0d got %b want %b", cyc, shot_trig, cyc == next_trig);
         end
         n_checks++;
         if (acc_clear !== ((cyc == next_trig) && clr)) begin
            n_fail++;
            $display("FAIL acc_clear cyc=%0d got %b want %b", cyc, acc_clear,
                     (cyc == next_trig) && clr);
         end
         n_checks++;
         if (busy !== m_busy) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, m_busy);
         end
         n_checks++;
         if (shotcnt !== NW'(m_cnt)) begin
            n_fail++;
            $display("FAIL shotcnt cyc=%0d got %0d want %0d", cyc, shotcnt, m_cnt);
         end
         n_checks++;
         if (lastshotdone !== m_last) begin
            n_fail++;
            $display("FAIL lastshotdone cyc=%0d got %b want %b", cyc, lastshotdone, m_last);
         end
         if (cyc == next_trig) begin
            clr      = 1'b0;
            done_cyc = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6)));
         end
         if (cyc == done_cyc) begin
            shot_done = 1'b1;
            dones++;
            done_cyc = -1;
            if (dones == abort_at) begin
               stb_abort = 1'b1;
               m_busy    = 1'b0;
               next_trig = -1;
            end else begin
               m_cnt = dones;
               if (dones == n) begin
                  m_last    = 1'b1;
                  m_busy    = 1'b0;
                  next_trig = -1;
               end else begin
                  next_trig = cyc + 1 + g;
               end
            end
         end else if (noise) begin
            // Stray shot_done only while the DUT is in TRIG, GAP or IDLE
            if (next_trig >= 0 && cyc >= next_trig - g && cyc <= next_trig &&
                $urandom_range(0, 2) == 0) shot_done = 1'b1;
            if (!m_busy && $urandom_range(0, 2) == 0) shot_done = 1'b1;
            if (m_busy && $urandom_range(0, 3) == 0) begin
               stb_start = 1'b1;
               nshot     = NW'($urandom_range(1, 20));
               shotgap   = GW'($urandom);
               resetacc  = 1'b1;
            end
         end
         if (!m_busy) idle++;
         budget++;
         if (budget > 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout n=%0d got busy=%b want 0", n, busy);
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      stb_start = 1'b0;
      stb_abort = 1'b0;
      shot_done = 1'b0;
      nshot     = '0;
      shotgap   = '0;
      resetacc  = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({shot_trig, acc_clear, busy, lastshotdone} !== 4'b0 || shotcnt !== '0) begin
         n_fail++;
         $display("FAIL reset_state got trig=%b clr=%b busy=%b last=%b cnt=%0d want all 0",
                  shot_trig, acc_clear, busy, lastshotdone, shotcnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_run();
      run_shots(3, 0, 1'b1, 5, -1, 1'b0);
   endtask

   task automatic test_gap();
      run_shots(2, 4, 1'b0, 3, -1, 1'b0);
   endtask

   task automatic test_abort_with_done();
      run_shots(10, 1, 1'b0, 3, 5, 1'b0);
   endtask

   task automatic test_zero_shots();
      run_shots(0, 0, 1'b1, 3, -1, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      run_shots(4, 3, 1'b0, 0, -1, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      stb_start = 1'b1;
      nshot     = NW'(5);
      shotgap   = GW'(6);
      resetacc  = 1'b0;
      @(negedge clk);
      stb_start = 1'b0;
      @(negedge clk);
      shot_done = 1'b1;
      @(negedge clk);
      shot_done = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || shotcnt !== NW'(1)) begin
         n_fail++;
         $display("FAIL pre_reset_gap got busy=%b cnt=%0d want busy=1 cnt=1", busy, shotcnt);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({shot_trig, acc_clear, busy, lastshotdone} !== 4'b0 || shotcnt !== '0) begin
         n_fail++;
         $display("FAIL async_reset got trig=%b clr=%b busy=%b last=%b cnt=%0d want all 0",
                  shot_trig, acc_clear, busy, lastshotdone, shotcnt);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         n_checks++;
         if (shot_trig !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got trig=%b busy=%b want 0 0", shot_trig, busy);
         end
      end
      run_shots(1, 0, 1'b1, 2, -1, 1'b0);
   endtask

   task automatic test_random();
      int n;
      int ab;
      repeat (6) begin
         n  = int'($urandom_range(1, 6));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : -1;
         run_shots(n, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0, ab, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_gap();
      test_abort_with_done();
      test_zero_shots();
      test_ignored_inputs();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shot_sequencer.md
# shot_sequencer

DSP-domain responder to the configuration-side shot-control registers: it accepts the `stb_start`/`nshot` request, issues one trigger pulse per shot to the DSP core, and waits for the core's per-shot completion. It returns `shotcnt` and `lastshotdone` for readback through `dspregs`. It sits inside the DSP hierarchy on `dspclk`, between the `dspif` control fields and the element/accumulator logic.

## Interface
Parameters:
- `NSHOTWIDTH`, 32, width of `nshot` and `shotcnt`
- `GAPWIDTH`, 24, width of the inter-shot idle-gap count

Ports:
- `clk`  in  1  DSP clock (`dspclk`); single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `stb_start`  in  1  one-cycle start strobe
- `stb_abort`  in  1  one-cycle abort strobe
- `nshot`  in  NSHOTWIDTH  number of shots; sampled on accepted start
- `shotgap`  in  GAPWIDTH  idle cycles between `shot_done` and the next trigger; sampled on accepted start
- `resetacc`  in  1  when 1, pulse `acc_clear` at run start; sampled on accepted start
- `shot_done`  in  1  one-cycle pulse from the DSP core: the current shot has completed
- `shot_trig`  out  1  one-cycle pulse that starts a shot
- `acc_clear`  out  1  one-cycle accumulator clear pulse
- `shotcnt`  out  NSHOTWIDTH  completed shots in the current or most recent run
- `lastshotdone`  out  1  sticky; high once all `nshot` shots have completed
- `busy`  out  1  high in every state except IDLE

## Operation
- States are IDLE, TRIG, WAIT_DONE and GAP. All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- IDLE + `stb_start`, `nshot`≠0:
  - latch `nshot`, `shotgap` and `resetacc`
  - clear `shotcnt` and `lastshotdone`
  - go to TRIG
- IDLE + `stb_start`, `nshot`=0: `shotcnt`←0 and `lastshotdone`←1; the block stays in IDLE and issues no trigger.
- TRIG:
  - `shot_trig`=1 for exactly this cycle
  - `acc_clear`=1 on the first TRIG of a run if latched `resetacc`=1
  - next state is WAIT_DONE unconditionally
  - `shot_done` is ignored in TRIG
- WAIT_DONE + `shot_done`:
  - `shotcnt`←`shotcnt`+1
  - if the new count equals the latched `nshot`: `lastshotdone`←1, go to IDLE
  - else if latched gap = 0: go to TRIG
  - else: load the gap counter with the latched gap and go to GAP
- GAP:
  - the gap counter decrements each cycle
  - on the cycle the counter reads 1, the next state is TRIG
  - `shot_done` is ignored
- `stb_start` while `busy`=1 is ignored. Latched parameters do not change mid-run.
- `stb_abort` in any state:
  - next state is IDLE
  - `shotcnt` holds its value
  - `lastshotdone` stays 0
  - a pending trigger is cancelled
- Priority within one cycle: `stb_abort` beats `shot_done`, which beats `stb_start`.
- `shotcnt` never exceeds the latched `nshot`, so no wrap-around is possible. At `nshot`=2^NSHOTWIDTH−1 the count stops exactly at all-ones.
- `shot_done` in IDLE is ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `shot_trig`=0, `acc_clear`=0, `shotcnt`=0, `lastshotdone`=0, `busy`=0; latched parameters and gap counter = 0.
- Deassertion of `reset` is synchronized by the existing `areset` wrapper upstream. The block treats `reset` as async-assert only.
- `stb_start` sampled at edge t → `busy`=1, `shot_trig`=1 and (optionally) `acc_clear`=1 during cycle t+1.
- `shot_done` sampled at edge t, gap G:
  - G=0: next `shot_trig` in cycle t+1
  - G>0: next `shot_trig` in cycle t+1+G
- `shotcnt` updates in cycle t+1 after the `shot_done` edge t.
- Final `shot_done` at edge t → `lastshotdone`=1 and `busy`=0 in cycle t+1.
- `stb_abort` at edge t → `busy`=0 in cycle t+1, and no `shot_trig` at t+1 or later.
- Reset asserted mid-run: all outputs return to their reset values immediately, and no trigger is issued until a new `stb_start`.

## Test plan
- **Basic run.** `nshot`=3, `shotgap`=0, `resetacc`=1; respond to each `shot_trig` with `shot_done` 5 cycles later.
  - Expect 3 `shot_trig` pulses, with the 2nd and 3rd 1 cycle after their `shot_done`.
  - Expect `acc_clear` only with the first trigger.
  - Expect `shotcnt` to step 1, 2, 3, then `lastshotdone`=1 and `busy`=0.
- **Gap.** `nshot`=2, `shotgap`=4, `shot_done` at edge t → second `shot_trig` exactly in cycle t+5; `shotcnt`=2 at the end.
- **Zero shots.** `nshot`=0 start → no `shot_trig`, `busy` stays 0, `lastshotdone`=1 in the next cycle, `shotcnt`=0.
- **Abort with simultaneous completion.** `nshot`=10; after 4 shots, assert `stb_abort` in the same cycle as the 5th `shot_done`.
  - Expect `shotcnt`=4, `lastshotdone`=0, `busy`=0 the next cycle, and no further triggers.
- **Illegal and ignored inputs.**
  - `stb_start` pulses while busy → ignored; the run completes with its original `nshot`.
  - `shot_done` pulses in TRIG, GAP and IDLE → no count change.
- **Reset mid-run.** Assert `reset` during a GAP → all outputs read 0 immediately. A new `stb_start` with `nshot`=1 then completes normally with `shotcnt`=1.
